// File: rtl/cpu_ctrl_pkg.sv
// Shared control-bundle definitions for the MIPS pipeline: bit indices, widths,
// the NOP bundle and the ID/EX data payload.
package cpu_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 11;
    localparam int unsigned CNT_W  = 32;

    localparam int unsigned CTRL_JUMP    = 10;
    localparam int unsigned CTRL_BRANCH  = 9;
    localparam int unsigned CTRL_MEMRD   = 8;
    localparam int unsigned CTRL_MEMWR   = 7;
    localparam int unsigned CTRL_MEM2REG = 6;
    localparam int unsigned CTRL_ALUSRC  = 2;
    localparam int unsigned CTRL_REGWR   = 1;
    localparam int unsigned CTRL_REGDST  = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t CTRL_NOP = 11'b0;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } ex_payload_t;

    // R-format, store and branch instructions all read the rt register
    function automatic logic uses_rt(ctrl_t c);
        return c[CTRL_REGDST] | c[CTRL_MEMWR] | c[CTRL_BRANCH];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bus: decoder-side inputs, hold/flush controls, stall request and EX outputs.
// Perf counter outputs exist only when ID_EX_PERF_CNT_EN is defined.
interface id_ex_stage_if;
    import cpu_ctrl_pkg::*;

    logic              id_valid;
    ctrl_t             id_ctrl;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ex_hold;
    logic              flush;

    logic              id_stall;
    logic              ex_valid;
    ctrl_t             ex_ctrl;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  hold_cnt;
`endif

    modport master (
        output id_valid, id_ctrl, id_pc, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, ex_hold, flush,
`ifdef ID_EX_PERF_CNT_EN
        input  bubble_cnt, hold_cnt,
`endif
        input  id_stall, ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data,
               ex_imm, ex_rs, ex_rt, ex_rd
    );

    modport slave (
        input  id_valid, id_ctrl, id_pc, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, ex_hold, flush,
`ifdef ID_EX_PERF_CNT_EN
        output bubble_cnt, hold_cnt,
`endif
        output id_stall, ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data,
               ex_imm, ex_rs, ex_rt, ex_rd
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: a valid load in EX writing a nonzero rt
// that the valid ID instruction reads.
module load_use_detect
    import cpu_ctrl_pkg::*;
(
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_reg_write_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              id_valid_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    output logic              hazard_c_o
);

    logic ex_load_c;
    logic id_reads_c;

    assign ex_load_c  = ex_valid_i & ex_mem_read_i & ex_reg_write_i & (ex_rt_i != '0);
    assign id_reads_c = (ex_rt_i == id_rs_i) | ((ex_rt_i == id_rt_i) & id_uses_rt_i);
    assign hazard_c_o = ex_load_c & id_reads_c & id_valid_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold and flush.
// Define ID_EX_PERF_CNT_EN to add saturating bubble/hold counters.
module id_ex_stage
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    id_ex_stage_if.slave bus
);

    logic        ex_valid_q, ex_valid_d;
    ctrl_t       ex_ctrl_q,  ex_ctrl_d;
    ex_payload_t ex_data_q,  ex_data_d;
    ex_payload_t id_data_c;
    logic        hazard_c;

    assign id_data_c = '{pc:      bus.id_pc,
                         rs_data: bus.id_rs_data,
                         rt_data: bus.id_rt_data,
                         imm:     bus.id_imm,
                         rs:      bus.id_rs,
                         rt:      bus.id_rt,
                         rd:      bus.id_rd};

    load_use_detect u_load_use_detect (
        .ex_valid_i     (ex_valid_q),
        .ex_mem_read_i  (ex_ctrl_q[CTRL_MEMRD]),
        .ex_reg_write_i (ex_ctrl_q[CTRL_REGWR]),
        .ex_rt_i        (ex_data_q.rt),
        .id_valid_i     (bus.id_valid),
        .id_uses_rt_i   (uses_rt(bus.id_ctrl)),
        .id_rs_i        (bus.id_rs),
        .id_rt_i        (bus.id_rt),
        .hazard_c_o     (hazard_c)
    );

    assign bus.id_stall = (hazard_c | bus.ex_hold) & ~bus.flush;

    // Priority: flush > hold > load-use bubble > capture
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_data_d  = ex_data_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NOP;
        end else if (!bus.ex_hold) begin
            if (hazard_c) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = CTRL_NOP;
            end else begin
                ex_valid_d = bus.id_valid;
                ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : CTRL_NOP;
                ex_data_d  = id_data_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CTRL_NOP;
            ex_data_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_data_q  <= ex_data_d;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_pc      = ex_data_q.pc;
    assign bus.ex_rs_data = ex_data_q.rs_data;
    assign bus.ex_rt_data = ex_data_q.rt_data;
    assign bus.ex_imm     = ex_data_q.imm;
    assign bus.ex_rs      = ex_data_q.rs;
    assign bus.ex_rt      = ex_data_q.rt;
    assign bus.ex_rd      = ex_data_q.rd;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;

    // Saturating event counters; a flush overrides both events
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        if (!bus.flush && !bus.ex_hold && hazard_c && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (!bus.flush && bus.ex_hold && (hold_cnt_q != '1)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
    assign bus.hold_cnt   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed pipeline scenarios plus random
// instruction streams checked against a behavioural model of the EX slot.
module tb_id_ex_stage;
    import cpu_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus();
    id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [10:0] OP_R    = 11'h023;
    localparam logic [10:0] OP_LW   = 11'h146;
    localparam logic [10:0] OP_SW   = 11'h084;
    localparam logic [10:0] OP_ADDI = 11'h006;
    localparam logic [10:0] OP_BEQ  = 11'h200;

    typedef struct {
        logic        valid;
        logic        hold;
        logic        flush;
        logic [10:0] ctrl;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
    } slot_t;

    typedef struct {
        slot_t       ex;
        logic        stall;
        int unsigned bub;
        int unsigned hld;
    } exp_t;

    exp_t        expq[$];
    slot_t       ex_m;
    slot_t       cur;
    int unsigned bub_m;
    int unsigned hold_m;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{valid: 1'b0, hold: 1'b0, flush: 1'b0, ctrl: '0, pc: '0, rsd: '0,
              rtd: '0, imm: '0, rs: '0, rt: '0, rd: '0};
        return s;
    endfunction

    // A loaded value is not ready in EX; any younger reader of that register must wait
    function automatic logic load_use(input slot_t ex, input slot_t id);
        logic is_load;
        logic reads_rt;
        is_load  = ex.valid && ex.ctrl[8] && ex.ctrl[1] && (ex.rt != 5'd0);
        reads_rt = id.ctrl[0] || id.ctrl[7] || id.ctrl[9];
        return is_load && id.valid && ((ex.rt == id.rs) || (reads_rt && ex.rt == id.rt));
    endfunction

    function automatic slot_t mk(input logic v, input logic [10:0] c, input int rs,
                                 input int rt, input int rd, input logic h, input logic f);
        slot_t s;
        s.valid = v; s.ctrl = c; s.hold = h; s.flush = f;
        s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd);
        s.pc = $urandom; s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom;
        return s;
    endfunction

    function automatic slot_t rnd();
        logic [10:0] c;
        case ($urandom_range(0, 5))
            0: c = OP_R;
            1: c = OP_LW;
            2: c = OP_SW;
            3: c = OP_ADDI;
            4: c = OP_BEQ;
            default: c = 11'($urandom);
        endcase
        return mk($urandom_range(0, 9) != 0, c, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0);
    endfunction

    task automatic drive(input slot_t s);
        bus.id_valid   = s.valid;
        bus.id_ctrl    = s.ctrl;
        bus.id_pc      = s.pc;
        bus.id_rs_data = s.rsd;
        bus.id_rt_data = s.rtd;
        bus.id_imm     = s.imm;
        bus.id_rs      = s.rs;
        bus.id_rt      = s.rt;
        bus.id_rd      = s.rd;
        bus.ex_hold    = s.hold;
        bus.flush      = s.flush;
    endtask

    // What the edge just taken did to the EX slot, given the inputs that preceded it
    task automatic advance_model();
        if (cur.flush) begin
            ex_m.valid = 1'b0;
            ex_m.ctrl  = '0;
        end else if (cur.hold) begin
            if (hold_m != 32'hFFFF_FFFF) hold_m++;
        end else if (load_use(ex_m, cur)) begin
            ex_m.valid = 1'b0;
            ex_m.ctrl  = '0;
            if (bub_m != 32'hFFFF_FFFF) bub_m++;
        end else begin
            ex_m      = cur;
            ex_m.ctrl = cur.valid ? cur.ctrl : 11'd0;
        end
    endtask

    task automatic step(input slot_t s, input logic rst_val);
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n) advance_model();
        rst_n = rst_val;
        if (!rst_val) begin
            ex_m   = empty_slot();
            bub_m  = 0;
            hold_m = 0;
        end
        cur = s;
        drive(s);
        e.ex    = ex_m;
        e.stall = (load_use(ex_m, cur) || cur.hold) && !cur.flush;
        e.bub   = bub_m;
        e.hld   = hold_m;
        expq.push_back(e);
    endtask

    task automatic run(input slot_t s);
        step(s, 1'b1);
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("id_stall",   32'(bus.id_stall),   32'(e.stall));
            chk("ex_valid",   32'(bus.ex_valid),   32'(e.ex.valid));
            chk("ex_ctrl",    32'(bus.ex_ctrl),    32'(e.ex.ctrl));
            chk("ex_pc",      bus.ex_pc,           e.ex.pc);
            chk("ex_rs_data", bus.ex_rs_data,      e.ex.rsd);
            chk("ex_rt_data", bus.ex_rt_data,      e.ex.rtd);
            chk("ex_imm",     bus.ex_imm,          e.ex.imm);
            chk("ex_rs",      32'(bus.ex_rs),      32'(e.ex.rs));
            chk("ex_rt",      32'(bus.ex_rt),      32'(e.ex.rt));
            chk("ex_rd",      32'(bus.ex_rd),      32'(e.ex.rd));
`ifdef ID_EX_PERF_CNT_EN
            chk("bubble_cnt", bus.bubble_cnt, e.bub);
            chk("hold_cnt",   bus.hold_cnt,   e.hld);
`endif
        end
    end

    slot_t nop, ld, add;

    initial begin
        ex_m   = empty_slot();
        cur    = empty_slot();
        bub_m  = 0;
        hold_m = 0;
        drive(cur);
        nop = mk(1'b0, 11'd0, 0, 0, 0, 1'b0, 1'b0);

        // Reset release and plain R-format flow
        run(mk(1'b1, OP_R, 1, 2, 3, 1'b0, 1'b0));
        run(nop);
        #1;
        chk("rfmt_ctrl",  32'(bus.ex_ctrl), 32'h023);
        chk("rfmt_rd",    32'(bus.ex_rd),   32'd3);
        chk("rfmt_valid", 32'(bus.ex_valid), 32'd1);
        chk("rfmt_stall", 32'(bus.id_stall), 32'd0);

        // Load-use: one stall, one bubble, then the add is captured
        ld  = mk(1'b1, OP_LW, 1, 5, 0, 1'b0, 1'b0);
        add = mk(1'b1, OP_R, 5, 6, 7, 1'b0, 1'b0);
        run(ld);
        run(add);
        #1 chk("lu_stall", 32'(bus.id_stall), 32'd1);
        run(add);
        #1 chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_bubble_ctrl", 32'(bus.ex_ctrl), 32'd0);
        chk("lu_bubble_stall", 32'(bus.id_stall), 32'd0);
        run(nop);
        #1 chk("lu_captured", 32'(bus.ex_rs), 32'd5);

        // Load to $zero never stalls
        run(mk(1'b1, OP_LW, 1, 0, 0, 1'b0, 1'b0));
        run(mk(1'b1, OP_R, 0, 0, 7, 1'b0, 1'b0));
        #1 chk("lu_r0_stall", 32'(bus.id_stall), 32'd0);

        // addi reads only rs
        run(mk(1'b1, OP_LW, 1, 5, 0, 1'b0, 1'b0));
        run(mk(1'b1, OP_ADDI, 7, 5, 0, 1'b0, 1'b0));
        #1 chk("lu_addi_stall", 32'(bus.id_stall), 32'd0);

        // Store after load reads rt
        run(mk(1'b1, OP_LW, 1, 4, 0, 1'b0, 1'b0));
        run(mk(1'b1, OP_SW, 1, 4, 0, 1'b0, 1'b0));
        #1 chk("lu_sw_stall", 32'(bus.id_stall), 32'd1);
        run(nop);

        // Flush beats a pending hazard
        run(ld);
        run(mk(1'b1, OP_R, 5, 6, 7, 1'b0, 1'b1));
        #1 chk("flush_stall", 32'(bus.id_stall), 32'd0);
        run(nop);
        #1 chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_ctrl", 32'(bus.ex_ctrl), 32'd0);

        // Hold three edges with a store in EX
        run(mk(1'b1, OP_SW, 2, 3, 0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            run(mk(1'b1, OP_R, 1, 2, 3, 1'b1, 1'b0));
            #1 chk("hold_stall", 32'(bus.id_stall), 32'd1);
        end
        run(nop);
        #1 chk("hold_ctrl", 32'(bus.ex_ctrl), 32'(OP_SW));
`ifdef ID_EX_PERF_CNT_EN
        chk("hold_cnt_3", bus.hold_cnt, 32'd3);
`endif

        for (int i = 0; i < 400; i++) run(rnd());

        // Asynchronous reset mid-stream
        @(posedge clk);
        #1;
        advance_model();
        cur = mk(1'b1, OP_R, 1, 2, 3, 1'b0, 1'b0);
        drive(cur);
        #2;
        rst_n = 1'b0;
        ex_m   = empty_slot();
        bub_m  = 0;
        hold_m = 0;
        #1;
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ctrl",  32'(bus.ex_ctrl),  32'd0);
        chk("rst_pc",    bus.ex_pc,         32'd0);
        chk("rst_rd",    32'(bus.ex_rd),    32'd0);
        step(cur, 1'b0);
        step(cur, 1'b1);
        for (int i = 0; i < 200; i++) run(rnd());

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
